// File: rtl/wrap_ref_pingpong_pkg.sv
// rtl/wrap_ref_pingpong_pkg.sv - shared pixel/bank definitions for the ping-pong reference buffer
package wrap_ref_pingpong_pkg;

  localparam int PIXEL_WIDTH    = 8;
  localparam int PIX_NUM_LUMA   = 48;
  localparam int PIX_NUM_CHROMA = 24;

  typedef enum logic {
    BANK_0 = 1'b0,
    BANK_1 = 1'b1
  } bank_e;

  function automatic bank_e other_bank(input bank_e b);
    return (b == BANK_0) ? BANK_1 : BANK_0;
  endfunction

endpackage

// File: rtl/wrap_ref_pingpong_rf_1p.sv
// rtl/wrap_ref_pingpong_rf_1p.sv - single-port register file, active-low enables, 1-cycle read
module wrap_ref_pingpong_rf_1p #(
  parameter int Addr_Width = 6,
  parameter int Word_Width = 384
) (
  input  logic                  clk,
  input  logic                  cen,
  input  logic                  wen,
  input  logic [Addr_Width-1:0] addr,
  input  logic [Word_Width-1:0] data_i,
  output logic [Word_Width-1:0] data_o
);

  logic [Word_Width-1:0] mem [0:(1<<Addr_Width)-1];

  // Contents are never reset; a write cycle leaves the read register untouched.
  always_ff @(posedge clk) begin
    if (!cen) begin
      if (!wen) begin
        mem[addr] <= data_i;
      end else begin
        data_o <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/wrap_ref_pingpong.sv
// rtl/wrap_ref_pingpong.sv - ping-pong reference-pixel buffer: fetch fills one bank, ME/MC reads the other
module wrap_ref_pingpong
  import wrap_ref_pingpong_pkg::*;
#(
  parameter int PIX_W   = PIXEL_WIDTH,
  parameter int PIX_NUM = PIX_NUM_LUMA,
  parameter int ADDR_W  = 6
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clr_i,
  input  logic                     wrif_en_i,
  input  logic [ADDR_W-1:0]        wrif_addr_i,
  input  logic [PIX_NUM*PIX_W-1:0] wrif_data_i,
  input  logic                     wrif_done_i,
  output logic                     wrif_rdy_o,
  input  logic                     rdif_en_i,
  input  logic [ADDR_W-1:0]        rdif_addr_i,
  input  logic                     rdif_done_i,
  output logic                     rdif_rdy_o,
  output logic                     rdif_pvalid_o,
  output logic [PIX_NUM*PIX_W-1:0] rdif_pdata_o,
  output logic [1:0]               full_o
);

  localparam int DATA_W = PIX_NUM * PIX_W;

  bank_e       fill_sel, fill_sel_nxt;
  bank_e       work_sel, work_sel_nxt;
  bank_e       rd_sel_q;
  logic [1:0]  bank_full, bank_full_nxt;
  logic        wr_fire, rd_fire, wr_done, rd_done;

  logic [1:0]        bank_wen;
  logic [ADDR_W-1:0] bank_addr [2];
  logic [DATA_W-1:0] bank_q    [2];

  assign wrif_rdy_o = ~bank_full[fill_sel];
  assign rdif_rdy_o = bank_full[work_sel];
  assign full_o     = bank_full;

  assign wr_fire = wrif_en_i   & wrif_rdy_o;
  assign rd_fire = rdif_en_i   & rdif_rdy_o;
  assign wr_done = wrif_done_i & wrif_rdy_o;
  assign rd_done = rdif_done_i & rdif_rdy_o;

  // When both dones fire, the fill bank is empty and the work bank is full, so they differ.
  always_comb begin
    bank_full_nxt = bank_full;
    fill_sel_nxt  = fill_sel;
    work_sel_nxt  = work_sel;
    if (wr_done) begin
      bank_full_nxt[fill_sel] = 1'b1;
      fill_sel_nxt            = other_bank(fill_sel);
    end
    if (rd_done) begin
      bank_full_nxt[work_sel] = 1'b0;
      work_sel_nxt            = other_bank(work_sel);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bank_full     <= 2'b00;
      fill_sel      <= BANK_0;
      work_sel      <= BANK_0;
      rd_sel_q      <= BANK_0;
      rdif_pvalid_o <= 1'b0;
    end else if (clr_i) begin
      bank_full     <= 2'b00;
      fill_sel      <= BANK_0;
      work_sel      <= BANK_0;
      rd_sel_q      <= BANK_0;
      rdif_pvalid_o <= 1'b0;
    end else begin
      bank_full     <= bank_full_nxt;
      fill_sel      <= fill_sel_nxt;
      work_sel      <= work_sel_nxt;
      rdif_pvalid_o <= rd_fire;
      if (rd_fire) begin
        rd_sel_q <= work_sel;
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    assign bank_wen[g]  = ~(wr_fire & (fill_sel == bank_e'(g)));
    assign bank_addr[g] = bank_wen[g] ? rdif_addr_i : wrif_addr_i;

    wrap_ref_pingpong_rf_1p #(
      .Addr_Width (ADDR_W),
      .Word_Width (DATA_W)
    ) u_bank (
      .clk    (clk),
      .cen    (1'b0),
      .wen    (bank_wen[g]),
      .addr   (bank_addr[g]),
      .data_i (wrif_data_i),
      .data_o (bank_q[g])
    );
  end

  assign rdif_pdata_o = bank_q[rd_sel_q];

endmodule

// File: tb/tb_wrap_ref_pingpong.sv
// tb/tb_wrap_ref_pingpong.sv - scoreboard bench for the ping-pong reference buffer
module tb_wrap_ref_pingpong;

  localparam int PIX_W  = 8;
  localparam int PIX_NUM = 48;
  localparam int ADDR_W = 6;
  localparam int DATA_W = PIX_W * PIX_NUM;

  logic              clk = 1'b0;
  logic              rstn;
  logic              clr_i;
  logic              wrif_en_i;
  logic [ADDR_W-1:0] wrif_addr_i;
  logic [DATA_W-1:0] wrif_data_i;
  logic              wrif_done_i;
  logic              wrif_rdy_o;
  logic              rdif_en_i;
  logic [ADDR_W-1:0] rdif_addr_i;
  logic              rdif_done_i;
  logic              rdif_rdy_o;
  logic              rdif_pvalid_o;
  logic [DATA_W-1:0] rdif_pdata_o;
  logic [1:0]        full_o;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_q [$];

  wrap_ref_pingpong #(
    .PIX_W   (PIX_W),
    .PIX_NUM (PIX_NUM),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .clr_i         (clr_i),
    .wrif_en_i     (wrif_en_i),
    .wrif_addr_i   (wrif_addr_i),
    .wrif_data_i   (wrif_data_i),
    .wrif_done_i   (wrif_done_i),
    .wrif_rdy_o    (wrif_rdy_o),
    .rdif_en_i     (rdif_en_i),
    .rdif_addr_i   (rdif_addr_i),
    .rdif_done_i   (rdif_done_i),
    .rdif_rdy_o    (rdif_rdy_o),
    .rdif_pvalid_o (rdif_pvalid_o),
    .rdif_pdata_o  (rdif_pdata_o),
    .full_o        (full_o)
  );

  always #5 clk = ~clk;

  // Each fill generation gets its own byte pattern so stale or misplaced words are visible.
  function automatic logic [DATA_W-1:0] pat(input int a, input int gen);
    logic [7:0] v;
    v = 8'(a + gen * 64);
    return {PIX_NUM{v}};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrif_en_i   = 1'b0;
    wrif_done_i = 1'b0;
    rdif_en_i   = 1'b0;
    rdif_done_i = 1'b0;
    clr_i       = 1'b0;
  endtask

  task automatic rd_req(input int a, input logic expect_data, input logic [DATA_W-1:0] d);
    rdif_en_i   = 1'b1;
    rdif_addr_i = ADDR_W'(a);
    if (expect_data) exp_q.push_back(d);
  endtask

  // Monitor: every presented read word is popped and compared independently of the stimulus.
  always @(negedge clk) begin
    if (rstn && rdif_pvalid_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: got %h expected no pvalid", rdif_pdata_o[7:0]);
      end else begin
        logic [DATA_W-1:0] e;
        e = exp_q.pop_front();
        if (rdif_pdata_o !== e) begin
          bad++;
          $display("FAIL rd_data: got %h expected %h", rdif_pdata_o[15:0], e[15:0]);
        end
      end
    end
  end

  initial begin
    rstn        = 1'b0;
    wrif_addr_i = '0;
    wrif_data_i = '0;
    rdif_addr_i = '0;
    idle();
    repeat (3) step();
    chk("rst_wrif_rdy", 32'(wrif_rdy_o), 1);
    chk("rst_rdif_rdy", 32'(rdif_rdy_o), 0);
    chk("rst_pvalid", 32'(rdif_pvalid_o), 0);
    chk("rst_full", 32'(full_o), 0);
    rstn = 1'b1;
    step();

    // Read while empty is ignored
    rd_req(2, 1'b0, '0);
    step();
    idle();
    chk("empty_rd_pvalid", 32'(rdif_pvalid_o), 0);

    // Fill bank0
    for (int a = 0; a < 64; a++) begin
      wrif_en_i   = 1'b1;
      wrif_addr_i = ADDR_W'(a);
      wrif_data_i = pat(a, 0);
      step();
    end
    idle();
    wrif_done_i = 1'b1;
    step();
    idle();
    chk("fill0_full", 32'(full_o), 1);
    chk("fill0_rdif_rdy", 32'(rdif_rdy_o), 1);
    chk("fill0_wrif_rdy", 32'(wrif_rdy_o), 1);

    rd_req(5, 1'b1, pat(5, 0));
    step();
    idle();
    chk("rd5_pvalid", 32'(rdif_pvalid_o), 1);

    // Overlap: fill bank1 while reading bank0
    for (int a = 0; a < 64; a++) begin
      wrif_en_i   = 1'b1;
      wrif_addr_i = ADDR_W'(a);
      wrif_data_i = pat(a, 1);
      rd_req(63 - a, 1'b1, pat(63 - a, 0));
      step();
    end
    idle();
    wrif_done_i = 1'b1;
    step();
    idle();
    chk("both_full", 32'(full_o), 3);
    chk("both_full_wrif_rdy", 32'(wrif_rdy_o), 0);

    // Dropped write and ignored done while both banks are full
    wrif_en_i   = 1'b1;
    wrif_addr_i = ADDR_W'(7);
    wrif_data_i = {DATA_W{1'b1}};
    wrif_done_i = 1'b1;
    step();
    idle();
    chk("drop_full", 32'(full_o), 3);

    // Release bank0 with a read in the same cycle: data still from bank0
    rd_req(9, 1'b1, pat(9, 0));
    rdif_done_i = 1'b1;
    step();
    idle();
    chk("rel0_full", 32'(full_o), 2);
    chk("rel0_rdif_rdy", 32'(rdif_rdy_o), 1);
    chk("rel0_wrif_rdy", 32'(wrif_rdy_o), 1);
    rd_req(7, 1'b1, pat(7, 1));
    step();
    idle();

    // Refill part of bank0; last write coincides with both dones
    for (int a = 0; a < 3; a++) begin
      wrif_en_i   = 1'b1;
      wrif_addr_i = ADDR_W'(a);
      wrif_data_i = pat(a, 2);
      step();
    end
    wrif_en_i   = 1'b1;
    wrif_addr_i = ADDR_W'(3);
    wrif_data_i = pat(3, 2);
    wrif_done_i = 1'b1;
    rdif_done_i = 1'b1;
    step();
    idle();
    chk("simul_full", 32'(full_o), 1);
    chk("simul_wrif_rdy", 32'(wrif_rdy_o), 1);
    chk("simul_rdif_rdy", 32'(rdif_rdy_o), 1);
    rd_req(3, 1'b1, pat(3, 2));
    step();
    rd_req(10, 1'b1, pat(10, 0));
    step();
    idle();

    // clr_i wins over a read in the same cycle
    rd_req(1, 1'b0, '0);
    clr_i = 1'b1;
    step();
    idle();
    chk("clr_pvalid", 32'(rdif_pvalid_o), 0);
    chk("clr_full", 32'(full_o), 0);
    chk("clr_wrif_rdy", 32'(wrif_rdy_o), 1);
    chk("clr_rdif_rdy", 32'(rdif_rdy_o), 0);

    // Pointers back at bank0: new word at addr 10 must come back, not the bank0 original
    wrif_en_i   = 1'b1;
    wrif_addr_i = ADDR_W'(10);
    wrif_data_i = pat(10, 3);
    wrif_done_i = 1'b1;
    step();
    idle();
    chk("post_clr_full", 32'(full_o), 1);
    rd_req(10, 1'b1, pat(10, 3));
    step();
    idle();
    repeat (3) step();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
